ahb_lite_tg_master: RTL and testbench
=====================================

Name: ahb_lite_tg_master

Overview:
- AHB-Lite master traffic generator/checker driving the FPGA-to-SoC AHB slave port (S0_* pins of the SoC FPGA interface wrapper).
- On start: writes NUM_WORDS 32-bit words from BASE_ADDR, reads them back, compares against the expected pattern, and reports pass/fail and error statistics.
- Upstream stage of the SoC interface; its AHB outputs connect 1:1 to the S0_* inputs.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- NUM_WORDS, 16, words per pass; range 1..65535.
- SEED, 32'hA5A5_0000, pattern seed.

Ports:
- hclk  in  1  AHB clock; only clock.
- hresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; ignored unless state IDLE or DONE.
- haddr  out  32  transfer address.
- hburst  out  3  constant 3'b000 (SINGLE).
- hmastlock  out  1  constant 0.
- hprot  out  4  constant 4'b0011 (non-cacheable, privileged, data).
- hsel  out  1  1 while busy, else 0.
- hsize  out  3  constant 3'b010 (word).
- htrans  out  2  2'b00 IDLE or 2'b10 NONSEQ.
- hwbe  out  4  4'hF during write data phase, else 0.
- hwdata  out  32  write data.
- hwrite  out  1  1 for write address phase.
- hready  in  1  transfer done / wait state.
- hrdata  in  32  read data.
- hresp  in  1  1 = ERROR.
- busy  out  1  state not IDLE/DONE.
- done  out  1  sticky; set on DONE entry, cleared by start.
- pass  out  1  valid when done; 1 iff mismatch_cnt==0 and resp_err_cnt==0.
- mismatch_cnt  out  16  saturating read-compare failure count.
- resp_err_cnt  out  16  saturating hresp error count.
- first_err_addr  out  32  haddr of first mismatch or response error in the pass; 0 if none.

Behaviour:
- Reset: all outputs 0, except constants (hburst 0, hprot 4'b0011, hsize 3'b010); state IDLE; counters 0.
- Reset mid-transfer: outputs return to reset values immediately (async); no transfer completes.
- Transfers are non-overlapped: address phase, then data phase; htrans=IDLE throughout each data phase.
- FSM: IDLE -start-> WADDR -> WDATA -> (next word: WADDR | last word: RADDR) -> RDATA -> (next word: RADDR | last word: DONE) -start-> WADDR.
- WADDR/RADDR: htrans=NONSEQ, haddr=BASE_ADDR+4*idx, hwrite=1 in WADDR, 0 in RADDR.
  - Held stable until hready=1 is sampled, then advance to the data phase.
- WDATA/RDATA: held until hready=1 is sampled.
  - hwdata=pattern(idx) stable for the whole WDATA phase.
  - hrdata is sampled only on the hready=1 cycle of RDATA.
- Error response: if hresp=1 on the completing cycle, increment resp_err_cnt and skip the compare; the sequence continues (no abort).
- Compare: hrdata!=pattern(idx) increments mismatch_cnt.
- first_err_addr is latched once per pass, on the first error.
- Pattern: pattern(idx)=SEED+idx, modulo 2^32. idx is 16-bit; restarts at 0 for the read phase.
- Counters saturate at 16'hFFFF.
- start clears counters, first_err_addr and done, and resets idx to 0.
- Latency: with zero wait states, 4*NUM_WORDS cycles from start to done.
- NUM_WORDS=1: exactly one write, then one read.
- Address increments modulo 2^32.

Optional Feature:
- Macro AHB_TG_LFSR_PATTERN_EN.
- Defined: pattern is a 32-bit Galois LFSR, taps mask 32'h8020_0003, right-shift form.
  - Loaded with SEED (32'h1 if SEED==0) at the start of each phase.
  - Word 0 uses the seed value; advances once per completed data phase.
- Undefined: incrementing pattern SEED+idx; no LFSR logic synthesized.

Decomposition:
- Package ahb_tg_pkg:
  - htrans_t enum {IDLE=2'b00, NONSEQ=2'b10};
  - HSIZE_WORD, HBURST_SINGLE, HPROT_DATA constants;
  - tg_state_t enum;
  - LFSR taps constant.
- One sub-module ahb_tg_pattern_gen: inputs load, advance; outputs the 32-bit expected/write pattern; contains the macro-selected implementation.

Test Plan:
- Zero-wait memory model, NUM_WORDS=4, SEED=32'hA5A5_0000 -> writes 0xA5A50000..0xA5A50003 to 0x0,0x4,0x8,0xC; done after 16 cycles; pass=1.
- hready low for 3 cycles in every address and data phase -> haddr/hwdata/htrans held stable; identical data; done at 4*4*4=64 cycles; pass=1.
- Memory corrupts word 2 (returns 0) -> mismatch_cnt=1; first_err_addr=0x8; pass=0.
- hresp=1 on read of word 1 -> resp_err_cnt=1; mismatch_cnt=0; first_err_addr=0x4; pass=0; sequence completes.
- hresetn asserted during WDATA of word 2, then start -> all outputs zero during reset; full pass restarts at word 0; pass=1.
- With AHB_TG_LFSR_PATTERN_EN, SEED=1 -> word 0 = 0x00000001; word 1 = 0x80200003; pass=1.

Source files
------------

// File: rtl/ahb_tg_pkg.sv
// rtl/ahb_tg_pkg.sv - shared types and constants for the AHB-Lite traffic generator
package ahb_tg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        NONSEQ = 2'b10
    } htrans_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } tg_state_t;

    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [3:0]  HPROT_DATA    = 4'b0011;
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ahb_tg_pattern_gen.sv
// rtl/ahb_tg_pattern_gen.sv - write/expected data pattern source
// AHB_TG_LFSR_PATTERN_EN selects a Galois LFSR instead of the incrementing pattern.
module ahb_tg_pattern_gen
    import ahb_tg_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [31:0] o_pattern
);

    logic [31:0] r_pattern;

`ifdef AHB_TG_LFSR_PATTERN_EN
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_pattern <= LFSR_INIT;
        end else if (i_load) begin
            r_pattern <= LFSR_INIT;
        end else if (i_advance) begin
            r_pattern <= {1'b0, r_pattern[31:1]} ^ (r_pattern[0] ? LFSR_TAPS : 32'h0);
        end
    end
`else
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_pattern <= SEED;
        end else if (i_load) begin
            r_pattern <= SEED;
        end else if (i_advance) begin
            r_pattern <= r_pattern + 32'd1;
        end
    end
`endif

    assign o_pattern = r_pattern;

endmodule

// File: rtl/ahb_lite_tg_master.sv
// rtl/ahb_lite_tg_master.sv - AHB-Lite write/read-back traffic generator and checker
// Optional LFSR pattern via AHB_TG_LFSR_PATTERN_EN (see ahb_tg_pattern_gen).
module ahb_lite_tg_master
    import ahb_tg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_WORDS = 16,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        start,
    output logic [31:0] haddr,
    output logic [2:0]  hburst,
    output logic        hmastlock,
    output logic [3:0]  hprot,
    output logic        hsel,
    output logic [2:0]  hsize,
    output logic [1:0]  htrans,
    output logic [3:0]  hwbe,
    output logic [31:0] hwdata,
    output logic        hwrite,
    input  logic        hready,
    input  logic [31:0] hrdata,
    input  logic        hresp,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] resp_err_cnt,
    output logic [31:0] first_err_addr
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    tg_state_t   r_state;
    htrans_t     r_htrans;
    logic [15:0] r_idx;
    logic [31:0] r_haddr;
    logic [31:0] r_hwdata;
    logic [3:0]  r_hwbe;
    logic        r_hwrite;
    logic        r_hsel;
    logic        r_busy;
    logic        r_done;
    logic        r_err_seen;
    logic [15:0] r_mismatch;
    logic [15:0] r_resp_err;
    logic [31:0] r_first_err;

    logic [31:0] w_pattern;
    logic        w_start_ok;
    logic        w_last;
    logic        w_load;
    logic        w_advance;
    logic        w_rd_err;

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last     = (r_idx == LAST_IDX);
    // Reload on start and when the last write completes so reads replay from word 0.
    assign w_load     = w_start_ok || (r_state == ST_WDATA && hready && w_last);
    assign w_advance  = hready && (r_state == ST_WDATA || r_state == ST_RDATA);
    assign w_rd_err   = hresp || (hrdata != w_pattern);

    ahb_tg_pattern_gen #(.SEED(SEED)) u_pattern (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .i_load    (w_load),
        .i_advance (w_advance),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= ST_IDLE;
            r_htrans    <= IDLE;
            r_idx       <= 16'd0;
            r_haddr     <= 32'd0;
            r_hwdata    <= 32'd0;
            r_hwbe      <= 4'd0;
            r_hwrite    <= 1'b0;
            r_hsel      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_seen  <= 1'b0;
            r_mismatch  <= 16'd0;
            r_resp_err  <= 16'd0;
            r_first_err <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_WADDR;
                        r_htrans    <= NONSEQ;
                        r_idx       <= 16'd0;
                        r_haddr     <= BASE_ADDR;
                        r_hwrite    <= 1'b1;
                        r_hsel      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err_seen  <= 1'b0;
                        r_mismatch  <= 16'd0;
                        r_resp_err  <= 16'd0;
                        r_first_err <= 32'd0;
                    end
                end
                ST_WADDR: begin
                    if (hready) begin
                        r_state  <= ST_WDATA;
                        r_htrans <= IDLE;
                        r_hwrite <= 1'b0;
                        r_hwbe   <= 4'hF;
                        r_hwdata <= w_pattern;
                    end
                end
                ST_WDATA: begin
                    if (hready) begin
                        r_hwbe   <= 4'h0;
                        r_htrans <= NONSEQ;
                        if (w_last) begin
                            r_state  <= ST_RADDR;
                            r_idx    <= 16'd0;
                            r_haddr  <= BASE_ADDR;
                            r_hwrite <= 1'b0;
                        end else begin
                            r_state  <= ST_WADDR;
                            r_idx    <= r_idx + 16'd1;
                            r_haddr  <= r_haddr + 32'd4;
                            r_hwrite <= 1'b1;
                        end
                    end
                end
                ST_RADDR: begin
                    if (hready) begin
                        r_state  <= ST_RDATA;
                        r_htrans <= IDLE;
                    end
                end
                ST_RDATA: begin
                    if (hready) begin
                        // An error response carries no valid data, so the compare is skipped.
                        if (hresp) begin
                            r_resp_err <= sat_inc(r_resp_err);
                        end else if (hrdata != w_pattern) begin
                            r_mismatch <= sat_inc(r_mismatch);
                        end
                        if (w_rd_err && !r_err_seen) begin
                            r_err_seen  <= 1'b1;
                            r_first_err <= r_haddr;
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_hsel  <= 1'b0;
                            r_haddr <= 32'd0;
                        end else begin
                            r_state  <= ST_RADDR;
                            r_htrans <= NONSEQ;
                            r_idx    <= r_idx + 16'd1;
                            r_haddr  <= r_haddr + 32'd4;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign haddr          = r_haddr;
    assign hburst         = HBURST_SINGLE;
    assign hmastlock      = 1'b0;
    assign hprot          = HPROT_DATA;
    assign hsel           = r_hsel;
    assign hsize          = HSIZE_WORD;
    assign htrans         = r_htrans;
    assign hwbe           = r_hwbe;
    assign hwdata         = r_hwdata;
    assign hwrite         = r_hwrite;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_done && (r_mismatch == 16'd0) && (r_resp_err == 16'd0);
    assign mismatch_cnt   = r_mismatch;
    assign resp_err_cnt   = r_resp_err;
    assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_ahb_lite_tg_master.sv
// tb/tb_ahb_lite_tg_master.sv - self-checking bench for ahb_lite_tg_master
module tb_ahb_lite_tg_master;

    localparam logic [31:0] TB_SEED = 32'hA5A5_0000;
    localparam int          TB_N    = 4;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] haddr, hwdata, hrdata, first_err_addr;
    logic [2:0]  hburst, hsize;
    logic [3:0]  hprot, hwbe;
    logic [1:0]  htrans;
    logic        hmastlock, hsel, hwrite, busy, done, pass;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [15:0] mismatch_cnt, resp_err_cnt;

    ahb_lite_tg_master #(.BASE_ADDR(32'h0), .NUM_WORDS(TB_N), .SEED(TB_SEED)) dut (
        .hclk(hclk), .hresetn(hresetn), .start(start),
        .haddr(haddr), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
        .hsel(hsel), .hsize(hsize), .htrans(htrans), .hwbe(hwbe),
        .hwdata(hwdata), .hwrite(hwrite), .hready(hready), .hrdata(hrdata),
        .hresp(hresp), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .resp_err_cnt(resp_err_cnt),
        .first_err_addr(first_err_addr)
    );

    always #5 hclk = ~hclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int idx);
        logic [31:0] v;
`ifdef AHB_TG_LFSR_PATTERN_EN
        v = (TB_SEED == 32'h0) ? 32'h1 : TB_SEED;
        for (int k = 0; k < idx; k++)
            v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
`else
        v = TB_SEED + 32'(idx);
`endif
        return v;
    endfunction

    // Memory slave: waits inserted per phase, optional corrupted word and error word.
    logic [31:0] mem [16];
    int          s_waits = 0, s_cidx = -1, s_eidx = -1, unstable = 0;
    int          wcnt = 0;
    bit          dphase = 0, d_write = 0;
    logic [31:0] d_addr = 0;
    logic [31:0] p_haddr = 0, p_hwdata = 0;
    logic [1:0]  p_htrans = 0;
    logic        p_hwrite = 0;

    initial hrdata = 32'h0;

    always @(negedge hclk) begin
        if (!hresetn) begin
            dphase = 0; wcnt = 0; hready = 1'b1; hresp = 1'b0;
        end else begin
            if (!hready && (haddr !== p_haddr || hwdata !== p_hwdata ||
                            htrans !== p_htrans || hwrite !== p_hwrite))
                unstable++;
            p_haddr = haddr; p_hwdata = hwdata; p_htrans = htrans; p_hwrite = hwrite;
            hresp = 1'b0;
            if (dphase || htrans == 2'b10) begin
                if (wcnt < s_waits) begin
                    hready = 1'b0; wcnt++;
                end else begin
                    hready = 1'b1; wcnt = 0;
                    if (dphase) begin
                        if (d_write) mem[d_addr[5:2]] = hwdata;
                        else begin
                            hrdata = (int'(d_addr[5:2]) == s_cidx) ? 32'h0 : mem[d_addr[5:2]];
                            hresp  = (int'(d_addr[5:2]) == s_eidx);
                        end
                        dphase = 0;
                    end else begin
                        dphase = 1; d_addr = haddr; d_write = hwrite;
                    end
                end
            end else begin
                hready = 1'b1;
            end
        end
    end

    task automatic run_pass(input int w, input int c, input int e, output int cyc);
        s_waits = w; s_cidx = c; s_eidx = e; unstable = 0;
        @(negedge hclk); start = 1'b1;
        @(posedge hclk); #1 start = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge hclk); #1;
            cyc++;
            if (done) break;
        end
    endtask

    task automatic check_pass(input int cyc, input int ecyc, input int em, input int er,
                              input logic [31:0] efirst, input logic epass);
        chk("cycles", 32'(cyc), 32'(ecyc));
        chk("done", {31'b0, done}, 32'd1);
        chk("idle_bus", {busy, hsel, htrans}, 32'd0);
        chk("mismatch_cnt", {16'b0, mismatch_cnt}, 32'(em));
        chk("resp_err_cnt", {16'b0, resp_err_cnt}, 32'(er));
        chk("first_err_addr", first_err_addr, efirst);
        chk("pass", {31'b0, pass}, {31'b0, epass});
        chk("hold_stable", 32'(unstable), 32'd0);
        for (int i = 0; i < TB_N; i++) chk("mem_word", mem[i], pat(i));
    endtask

    task automatic check_reset_outputs();
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_ctrl", {htrans, hwrite, hsel, hwbe, busy, done, pass, hmastlock}, 32'h0);
        chk("rst_const", {hburst, hprot, hsize}, {22'b0, 3'b000, 4'b0011, 3'b010});
        chk("rst_cnt", {mismatch_cnt, resp_err_cnt}, 32'h0);
        chk("rst_first", first_err_addr, 32'h0);
    endtask

    typedef struct {
        int          waits;
        int          cidx;
        int          eidx;
        int          cyc;
        int          mm;
        int          re;
        logic [31:0] first;
        logic        ps;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cyc, w, c, e, em, er, lo;
        tbl[0] = '{0, -1, -1, 16, 0, 0, 32'h0, 1'b1};
        tbl[1] = '{3, -1, -1, 64, 0, 0, 32'h0, 1'b1};
        tbl[2] = '{0,  2, -1, 16, 1, 0, 32'h8, 1'b0};
        tbl[3] = '{0, -1,  1, 16, 0, 1, 32'h4, 1'b0};
        tbl[4] = '{1,  1,  3, 32, 1, 1, 32'h4, 1'b0};
        tbl[5] = '{2,  2,  2, 48, 0, 1, 32'h8, 1'b0};
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        repeat (2) @(negedge hclk);
        check_reset_outputs();
        hresetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_pass(tbl[i].waits, tbl[i].cidx, tbl[i].eidx, cyc);
            check_pass(cyc, tbl[i].cyc, tbl[i].mm, tbl[i].re, tbl[i].first, tbl[i].ps);
        end

        for (int r = 0; r < 6; r++) begin
            w = int'($urandom_range(0, 2));
            c = int'($urandom_range(0, 5)); if (c >= TB_N) c = -1;
            e = int'($urandom_range(0, 5)); if (e >= TB_N) e = -1;
            em = (c >= 0 && c != e) ? 1 : 0;
            er = (e >= 0) ? 1 : 0;
            lo = TB_N;
            if (em == 1) lo = c;
            if (er == 1 && e < lo) lo = e;
            run_pass(w, c, e, cyc);
            check_pass(cyc, 4 * TB_N * (w + 1), em, er,
                       (lo < TB_N) ? 32'(4 * lo) : 32'h0, (em == 0 && er == 0));
        end

        s_waits = 0; s_cidx = -1; s_eidx = -1;
        @(negedge hclk); start = 1'b1;
        @(posedge hclk); #1 start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge hclk);
            if (hwbe == 4'hF && haddr == 32'h8) break;
        end
        chk("reached_wdata2", {hwbe, haddr}, {4'hF, 32'h8});
        #2 hresetn = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        run_pass(0, -1, -1, cyc);
        check_pass(cyc, 16, 0, 0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
